// File: rtl/clint_timer_pkg.sv
// Shared CLINT definitions: bus widths, register offsets, mtimecmp reset value.
// Latency: n/a (package). Backpressure: n/a.
package clint_timer_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [15:0] MSIP_OFF        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MT_LO,
        REG_MT_HI
    } reg_sel_e;

    function automatic reg_sel_e decode_off(input logic [15:0] off);
        case (off)
            MSIP_OFF:        decode_off = REG_MSIP;
            MTIMECMP_LO_OFF: decode_off = REG_CMP_LO;
            MTIMECMP_HI_OFF: decode_off = REG_CMP_HI;
            MTIME_LO_OFF:    decode_off = REG_MT_LO;
            MTIME_HI_OFF:    decode_off = REG_MT_HI;
            default:         decode_off = REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk_i by DIV, pulsing tick_o high for one cycle every DIV cycles.
// Latency: tick_o is combinational from the registered count.
// Backpressure: none, free-running.
module clint_prescaler #(
    parameter int unsigned DIV = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic tick_o
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt_q;

    assign tick_o = (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Core-local timer/software interrupt source with mtime, mtimecmp and msip; CLINT_MTIME_LATCH_EN adds a tear-free mtime-high shadow.
// Latency: request sampled at edge N is acked with read data in the cycle after edge N+1.
// Backpressure: none, every request is accepted and acked, one per cycle.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ack_o,
    output logic                  mip_timer_o,
    output logic                  mip_sw_o
);

    logic                  tick;
    logic [63:0]           mtime_q;
    logic [63:0]           mtimecmp_q;
    logic                  msip_q;
    logic                  pend_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] mt_hi_rd;
    logic                  wr;
    logic                  rd;
    reg_sel_e              sel;

    clint_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .tick_o  (tick)
    );

    assign sel = (addr_i[31:16] == BASE_ADDR[31:16]) ? decode_off(addr_i[15:0]) : REG_NONE;
    assign wr  = req_i & we_i;
    assign rd  = req_i & ~we_i;

`ifdef CLINT_MTIME_LATCH_EN
    logic [31:0] shadow_q;

    // High half is captured with the low-half read so a lo/hi pair never tears.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shadow_q <= '0;
        end else if (rd && sel == REG_MT_LO) begin
            shadow_q <= mtime_q[63:32];
        end
    end

    assign mt_hi_rd = shadow_q;
`else
    assign mt_hi_rd = mtime_q[63:32];
`endif

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_MSIP:   rd_val = {31'd0, msip_q};
            REG_CMP_LO: rd_val = mtimecmp_q[31:0];
            REG_CMP_HI: rd_val = mtimecmp_q[63:32];
            REG_MT_LO:  rd_val = mtime_q[31:0];
            REG_MT_HI:  rd_val = mt_hi_rd;
            default:    rd_val = '0;
        endcase
    end

    // A write to either mtime half suppresses that edge's tick entirely.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mtime_q <= '0;
        end else if (wr && sel == REG_MT_LO) begin
            mtime_q[31:0] <= wdata_i;
        end else if (wr && sel == REG_MT_HI) begin
            mtime_q[63:32] <= wdata_i;
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
        end else if (wr) begin
            if (sel == REG_CMP_LO) mtimecmp_q[31:0]  <= wdata_i;
            if (sel == REG_CMP_HI) mtimecmp_q[63:32] <= wdata_i;
            if (sel == REG_MSIP)   msip_q            <= wdata_i[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q      <= 1'b0;
            rd_q        <= '0;
            ack_o       <= 1'b0;
            rdata_o     <= '0;
            mip_timer_o <= 1'b0;
            mip_sw_o    <= 1'b0;
        end else begin
            pend_q      <= req_i;
            rd_q        <= rd ? rd_val : '0;
            ack_o       <= pend_q;
            rdata_o     <= pend_q ? rd_q : '0;
            mip_timer_o <= (mtime_q >= mtimecmp_q);
            mip_sw_o    <= msip_q;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: two instances (TICK_DIV 1 and 4) on one shared bus.
`timescale 1ns/1ps
module tb_clint_timer;

    localparam logic [31:0] A_MSIP   = 32'h0200_0000;
    localparam logic [31:0] A_CMP_LO = 32'h0200_4000;
    localparam logic [31:0] A_CMP_HI = 32'h0200_4004;
    localparam logic [31:0] A_MT_LO  = 32'h0200_BFF8;
    localparam logic [31:0] A_MT_HI  = 32'h0200_BFFC;
    localparam logic [31:0] A_UNMAP  = 32'h0200_1234;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata0, rdata1;
    logic        ack0, ack1, mipt0, mipt1, mips0, mips1;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    clint_timer #(.TICK_DIV(1)) u_div1 (
        .clk_i(clk_i), .rst_n_i(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata0), .ack_o(ack0), .mip_timer_o(mipt0), .mip_sw_o(mips0)
    );

    clint_timer #(.TICK_DIV(4)) u_div4 (
        .clk_i(clk_i), .rst_n_i(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata1), .ack_o(ack1), .mip_timer_o(mipt1), .mip_sw_o(mips1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model state, one slot per instance
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp [2];
    logic        m_msip [2];
    int          m_pre [2];
    logic [31:0] m_shadow [2];
    logic        m_mipt [2];
    logic        m_mips [2];
    logic        m_p1 [2];
    logic        m_ack [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    task automatic model_edge(input int i, input int div);
        logic [31:0] rd;
        logic [15:0] off;
        logic        hit, is_wr, is_rd, tick;
        tick  = (m_pre[i] == div - 1);
        hit   = (addr_i[31:16] == 16'h0200);
        off   = addr_i[15:0];
        is_wr = req_i && we_i && hit;
        is_rd = req_i && !we_i && hit;
        rd    = '0;
        if (is_rd) begin
            if (off == 16'h0000) rd = {31'd0, m_msip[i]};
            else if (off == 16'h4000) rd = m_cmp[i][31:0];
            else if (off == 16'h4004) rd = m_cmp[i][63:32];
            else if (off == 16'hBFF8) begin
                rd = m_mtime[i][31:0];
`ifdef CLINT_MTIME_LATCH_EN
                m_shadow[i] = m_mtime[i][63:32];
`endif
            end else if (off == 16'hBFFC) begin
`ifdef CLINT_MTIME_LATCH_EN
                rd = m_shadow[i];
`else
                rd = m_mtime[i][63:32];
`endif
            end
        end
        m_ack[i] = m_p1[i];
        m_p1[i]  = req_i;
        if (req_i) begin
            if (i == 0) q0.push_back(rd);
            else q1.push_back(rd);
        end
        m_mipt[i] = (m_mtime[i] >= m_cmp[i]);
        m_mips[i] = m_msip[i];
        if (is_wr && off == 16'h0000) m_msip[i] = wdata_i[0];
        if (is_wr && off == 16'h4000) m_cmp[i][31:0] = wdata_i;
        if (is_wr && off == 16'h4004) m_cmp[i][63:32] = wdata_i;
        if (is_wr && off == 16'hBFF8) m_mtime[i][31:0] = wdata_i;
        else if (is_wr && off == 16'hBFFC) m_mtime[i][63:32] = wdata_i;
        else if (tick) m_mtime[i] = m_mtime[i] + 64'd1;
        m_pre[i] = tick ? 0 : m_pre[i] + 1;
    endtask

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_mtime[i] = '0; m_cmp[i] = 64'hFFFF_FFFF_FFFF_FFFF; m_msip[i] = 1'b0;
                m_pre[i] = 0; m_shadow[i] = '0; m_mipt[i] = 1'b0; m_mips[i] = 1'b0;
                m_p1[i] = 1'b0; m_ack[i] = 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            model_edge(0, 1);
            model_edge(1, 4);
        end
    end

    int          run0 = 0;
    int          peak0 = 0;
    logic [31:0] last1 = '0;

    always @(negedge clk_i) begin
        if (rst_n) begin
            check("mip_timer0", mipt0, m_mipt[0]);
            check("mip_timer1", mipt1, m_mipt[1]);
            check("mip_sw0", mips0, m_mips[0]);
            check("mip_sw1", mips1, m_mips[1]);
            check("ack0", ack0, m_ack[0]);
            check("ack1", ack1, m_ack[1]);
            if (ack0 && q0.size() != 0) check("rdata0", rdata0, q0.pop_front());
            else if (!ack0) check("rdata0_idle", rdata0, 32'd0);
            if (ack1 && q1.size() != 0) check("rdata1", rdata1, q1.pop_front());
            else if (!ack1) check("rdata1_idle", rdata1, 32'd0);
            if (ack1) last1 = rdata1;
            if (ack0) run0++;
            else run0 = 0;
            if (run0 > peak0) peak0 = run0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        @(posedge clk_i);
        #1;
        req_i = 1'b0; we_i = 1'b0; wdata_i = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        req_i = 1'b1; we_i = 1'b0; addr_i = a; wdata_i = '0;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
    endtask

    logic [31:0] va, vb;

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        #1;
        check("rst_ack", ack0, 1'b0);
        check("rst_rdata", rdata0, 32'd0);
        check("rst_mip_timer", mipt0, 1'b0);
        check("rst_mip_sw", mips0, 1'b0);
        @(posedge clk_i);
        #1;

        idle(10);
        bus_rd(A_MT_LO);

        bus_wr(A_MSIP, 32'd1);
        idle(1);
        check("mip_sw_set", mips0, 1'b1);
        bus_rd(A_MSIP);
        bus_wr(A_MSIP, 32'd0);
        idle(1);
        check("mip_sw_clr", mips0, 1'b0);
        bus_rd(A_MSIP);

        // mtime = k after the k-th edge following the mtime write
        bus_wr(A_CMP_HI, 32'd0);
        bus_wr(A_MT_LO, 32'd0);
        bus_wr(A_CMP_LO, 32'h20);
        idle(31);
        check("mip_timer_before", mipt0, 1'b0);
        idle(1);
        check("mip_timer_rise", mipt0, 1'b1);
        bus_wr(A_CMP_LO, 32'hFFFF_FFFF);
        idle(1);
        check("mip_timer_fall", mipt0, 1'b0);

        bus_wr(A_MT_LO, 32'hFFFF_FFFE);
        bus_wr(A_MT_HI, 32'h0000_0001);
        idle(2);
        bus_rd(A_MT_LO);
        bus_rd(A_MT_HI);
        idle(3);

        bus_wr(A_MT_HI, 32'h0000_0005);
        bus_wr(A_MT_LO, 32'hFFFF_FFFD);
        idle(2);
        peak0 = 0;
        bus_rd(A_MT_LO);
        bus_rd(A_MT_HI);
        bus_rd(A_UNMAP);
        idle(4);
        check("b2b_ack_run", peak0, 3);

        bus_wr(A_MT_LO, 32'd0);
        idle(2);
        bus_rd(A_MT_LO);
        idle(3);
        va = last1;
        idle(36);
        bus_rd(A_MT_LO);
        idle(3);
        vb = last1;
        check("div4_increments", vb - va, 32'd10);

        for (int k = 0; k < 8 && m_pre[1] != 3; k++) idle(1);
        bus_wr(A_MT_LO, 32'h0000_1000);
        bus_rd(A_MT_LO);
        idle(3);
        check("tick_edge_write", last1, 32'h0000_1000);

        bus_rd(32'h0300_BFF8);
        bus_wr(32'h0300_0000, 32'd1);
        idle(3);

        bus_rd(A_MT_LO);
        @(posedge clk_i);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", ack0, 1'b0);
        check("rst_mid_rdata", rdata0, 32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        idle(4);
        bus_rd(A_MT_LO);
        bus_rd(A_CMP_HI);
        idle(5);

        check("sb0_drained", q0.size(), 0);
        check("sb1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
